// File: rtl/debounce_dual.sv
// Two-channel push-button conditioner: 2-FF synchronizer, stability counter
// filter and registered rising-edge pulse per channel; channels share no state.

module debounce_chan #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic out,
  output logic rise
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    COUNT_UP,
    STABLE_HIGH,
    COUNT_DOWN
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic             at_last;

  always_comb begin
    at_last = (cnt == LAST);
  end

  // Stable states always hold cnt at zero, so with STABLE_CYCLES=1 the first
  // mismatching edge already reaches the terminal count and commits directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      state <= STABLE_LOW;
      out   <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      rise <= 1'b0;
      case (state)
        STABLE_LOW, COUNT_UP: begin
          if (!s2) begin
            cnt   <= '0;
            state <= STABLE_LOW;
          end else if (at_last) begin
            cnt   <= '0;
            out   <= 1'b1;
            rise  <= 1'b1;
            state <= STABLE_HIGH;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= COUNT_UP;
          end
        end
        STABLE_HIGH, COUNT_DOWN: begin
          if (s2) begin
            cnt   <= '0;
            state <= STABLE_HIGH;
          end else if (at_last) begin
            cnt   <= '0;
            out   <= 1'b0;
            state <= STABLE_LOW;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= COUNT_DOWN;
          end
        end
      endcase
    end
  end

endmodule

module debounce_dual #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_a,
  input  logic btn_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic b_rise
);

  debounce_chan #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_chan_a (
    .clk (clk),
    .rst (rst),
    .btn (btn_a),
    .out (a),
    .rise(a_rise)
  );

  debounce_chan #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_chan_b (
    .clk (clk),
    .rst (rst),
    .btn (btn_b),
    .out (b),
    .rise(b_rise)
  );

endmodule

// File: tb/tb_debounce_dual.sv
// Bench for debounce_dual: STABLE_CYCLES=4 and STABLE_CYCLES=1 instances share
// inputs; a window-based model is compared every cycle, plus directed timing pins.

module tb_debounce_dual;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_a = 1'b0;
  logic btn_b = 1'b0;
  logic a, b, a_rise, b_rise;
  logic a1, b1, a1_rise, b1_rise;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  debounce_dual #(.STABLE_CYCLES(4), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b),
    .a(a), .b(b), .a_rise(a_rise), .b_rise(b_rise)
  );

  debounce_dual #(.STABLE_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b),
    .a(a1), .b(b1), .a_rise(a1_rise), .b_rise(b1_rise)
  );

  // Model: channels 0,1 = dut (N=4), 2,3 = dut1 (N=1). The level flips to the
  // synchronized value once the last N filter samples since reset all equal it.
  logic [7:0] hist [4];
  int         nvalid [4];
  logic       s1m [4];
  logic       s2m [4];
  logic       outm [4];
  logic       risem [4];
  bit         cmp_en = 1'b0;

  always @(posedge clk) begin
    int n;
    logic obs;
    logic bin;
    logic [7:0] mask;
    for (int c = 0; c < 4; c++) begin
      n   = (c < 2) ? 4 : 1;
      bin = (c % 2 == 0) ? btn_a : btn_b;
      if (rst) begin
        s1m[c] = 1'b0; s2m[c] = 1'b0; outm[c] = 1'b0; risem[c] = 1'b0;
        hist[c] = '0; nvalid[c] = 0;
      end else begin
        obs = s2m[c];
        hist[c] = {hist[c][6:0], obs};
        if (nvalid[c] < 8) nvalid[c]++;
        mask = 8'((1 << n) - 1);
        risem[c] = 1'b0;
        if (nvalid[c] >= n && obs != outm[c] &&
            ((hist[c] & mask) == mask || (hist[c] & mask) == 8'h00)) begin
          outm[c]  = obs;
          risem[c] = obs;
        end
        s2m[c] = s1m[c];
        s1m[c] = bin;
      end
    end
    cmp_en = 1'b1;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model a", a, outm[0]);
      chk("model b", b, outm[1]);
      chk("model a_rise", a_rise, risem[0]);
      chk("model b_rise", b_rise, risem[1]);
      chk("model a1", a1, outm[2]);
      chk("model b1", b1, outm[3]);
      chk("model a1_rise", a1_rise, risem[2]);
      chk("model b1_rise", b1_rise, risem[3]);
    end
  end

  // Edge numbering: edge 1 is the first posedge after the stimulus change.
  task automatic measure(input bit use_n1, input logic target,
                         output int f_a, output int f_b,
                         output int p_a, output int p_b, output int hi_a);
    logic va, vb, ra, rb;
    f_a = 0; f_b = 0; p_a = 0; p_b = 0; hi_a = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      va = use_n1 ? a1 : a;
      vb = use_n1 ? b1 : b;
      ra = use_n1 ? a1_rise : a_rise;
      rb = use_n1 ? b1_rise : b_rise;
      if (va == target && f_a == 0) f_a = i;
      if (vb == target && f_b == 0) f_b = i;
      if (ra) p_a++;
      if (rb) p_b++;
      if (va) hi_a++;
    end
  endtask

  task automatic settle(input logic va, input logic vb);
    @(negedge clk);
    btn_a = va;
    btn_b = vb;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int fa, fb, pa, pb, ha;
    int bounce [7];
    int or_tbl [4];
    int pulses, highs, hold;
    bounce = '{1, 1, 1, 0, 1, 1, 0};
    or_tbl = '{0, 1, 1, 1};

    // Reset held for two edges with both buttons pressed.
    rst = 1'b1; btn_a = 1'b1; btn_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset a", a, 1'b0);
    chk("reset b", b, 1'b0);
    chk("reset a_rise", a_rise, 1'b0);
    rst = 1'b0;
    measure(1'b0, 1'b1, fa, fb, pa, pb, ha);
    chk_int("post-reset a edge", fa, 6);
    chk_int("post-reset a_rise count", pa, 1);

    // Clean press and release on channel A only.
    settle(1'b0, 1'b0);
    btn_a = 1'b1;
    measure(1'b0, 1'b1, fa, fb, pa, pb, ha);
    chk_int("press a edge", fa, 6);
    chk_int("press a_rise count", pa, 1);
    chk("press b idle", b, 1'b0);
    @(negedge clk);
    btn_a = 1'b0;
    measure(1'b0, 1'b0, fa, fb, pa, pb, ha);
    chk_int("release a edge", fa, 6);
    chk_int("release a_rise count", pa, 0);
    chk("release b idle", b, 1'b0);

    // Bounce shorter than the stable window must be rejected.
    settle(1'b0, 1'b0);
    pulses = 0; highs = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      btn_a = (i < 7) ? (bounce[i] != 0) : 1'b0;
      @(posedge clk);
      #1;
      if (a_rise) pulses++;
      if (a) highs++;
    end
    chk_int("bounce a high cycles", highs, 0);
    chk_int("bounce a_rise count", pulses, 0);
    @(negedge clk);
    btn_a = 1'b1;
    measure(1'b0, 1'b1, fa, fb, pa, pb, ha);
    chk_int("after bounce a edge", fa, 6);
    chk_int("after bounce a_rise count", pa, 1);

    // Reset pulse on the 4th edge of a count restarts the whole pipeline.
    settle(1'b0, 1'b0);
    btn_a = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-count reset a", a, 1'b0);
    rst = 1'b0;
    measure(1'b0, 1'b1, fa, fb, pa, pb, ha);
    chk_int("after mid reset a edge", fa, 6);
    chk_int("after mid reset a_rise count", pa, 1);

    // Simultaneous press on both channels.
    settle(1'b0, 1'b0);
    btn_a = 1'b1; btn_b = 1'b1;
    measure(1'b0, 1'b1, fa, fb, pa, pb, ha);
    chk_int("simul a edge", fa, 6);
    chk_int("simul b edge", fb, 6);
    chk_int("simul a_rise count", pa, 1);
    chk_int("simul b_rise count", pb, 1);

    // Downstream OR of the debounced levels.
    for (int i = 0; i < 4; i++) begin
      settle(i[1], i[0]);
      chk("or a level", a, i[1]);
      chk("or b level", b, i[0]);
      chk_int("or truth table", int'(a | b), or_tbl[i]);
    end

    // STABLE_CYCLES=1: a one-cycle press passes through with minimum latency.
    settle(1'b0, 1'b0);
    btn_a = 1'b1;
    @(negedge clk);
    btn_a = 1'b0;
    measure(1'b1, 1'b1, fa, fb, pa, pb, ha);
    chk_int("n1 a1 rise edge", fa, 2);
    chk_int("n1 a1 high cycles", ha, 1);
    chk_int("n1 a1_rise count", pa, 1);

    // Randomized bouncing with occasional resets; the model checks every cycle.
    for (int i = 0; i < 300; i++) begin
      hold = $urandom_range(1, 7);
      @(negedge clk);
      btn_a = 1'($urandom_range(0, 1));
      btn_b = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (hold - 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_dual.md
Name: debounce_dual

Overview:
- Two-channel push-button conditioner that sits directly upstream of the two-input logic gate stage (or_gate and its siblings).
- Takes raw, asynchronous, bouncing board switches and produces clean, synchronized levels that drive the gate's a and b inputs.
- Also produces one-cycle rising-edge pulses for event-driven logic.
- The two channels are identical and fully independent.

Parameters:
- STABLE_CYCLES, 4, consecutive clock edges a changed input must hold before the output follows; legal range 1..1048576.
- CNT_W, 20, counter width; must satisfy 2^CNT_W >= STABLE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- btn_a  input  1  raw switch A, asynchronous to clk, may bounce
- btn_b  input  1  raw switch B, asynchronous to clk, may bounce
- a  output  1  debounced level of btn_a; feeds gate input a
- b  output  1  debounced level of btn_b; feeds gate input b
- a_rise  output  1  one-cycle pulse on a 0->1 transition of a
- b_rise  output  1  one-cycle pulse on a 0->1 transition of b

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high: rst sampled high on a rising clk edge applies reset on that edge. No asynchronous reset path.
- Reset values: a=0, b=0, a_rise=0, b_rise=0, both synchronizer stages=0, both counters=0.
- Reset has priority over every other update, including mid-count. The count restarts from 0 after rst deasserts.
- Synchronizer, per channel:
  - Two flip-flops in series: s1 <= btn, s2 <= s1.
  - Only s2 is used by downstream logic.
  - Nothing else samples btn directly.
- Filter, per channel, evaluated each edge when rst=0; out is a or b:
  - if s2 == out: cnt <= 0, out unchanged.
  - else if cnt == STABLE_CYCLES-1: out <= s2, cnt <= 0.
  - else: cnt <= cnt+1, out unchanged.
- Equivalent view as a per-channel state machine:
  - STABLE_LOW: out=0, s2=0.
  - COUNT_UP: out=0, s2=1.
  - STABLE_HIGH: out=1, s2=1.
  - COUNT_DOWN: out=1, s2=0.
  - Any mismatch that lasts fewer than STABLE_CYCLES edges returns to the stable state with the counter cleared.
- Latency: btn stable before edge k -> out changes on edge k+1+STABLE_CYCLES.
  - s2 updates on edge k+1.
  - Mismatch is counted on edges k+2 .. k+1+STABLE_CYCLES.
  - With STABLE_CYCLES=4, out updates 6 edges after the input is first sampled.
- Same latency for rising and falling transitions.
- Glitch rejection: s2 returning to equal out at any point before the terminal count clears the counter. A partial count never carries over to a later mismatch.
- STABLE_CYCLES=1: out follows s2 on the first mismatching edge, i.e. pure 2-FF synchronizer plus 1 register.
- Edge pulse:
  - a_rise is registered and is 1 on exactly the edge where a goes 0->1, so it is high during the first cycle a==1. It is 0 otherwise.
  - a 1->0 transition produces no pulse.
  - b_rise behaves the same way for b.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around is possible.
- Simultaneous events: channels share no state. Both outputs may change on the same edge, and both pulses may assert together.
- Outputs are all registered; no combinational path from btn_* to any output.

Test Plan (STABLE_CYCLES=4 unless noted; edges counted from first sample):
- Reset: rst=1 for 2 edges, btn_a=btn_b=1 -> a=b=0, a_rise=b_rise=0 throughout reset. After rst=0, a=1 on 6th edge with a_rise=1 for exactly that one cycle.
- Clean press/release: btn_a 0->1 held 20 cycles, then 1->0 -> a=1 six edges after the press sample, a_rise high exactly 1 cycle. a=0 six edges after the release sample, no pulse on release. b stays 0.
- Bounce rejection: btn_a toggles high 3 cycles, low 1, high 2, low, then stable low -> a stays 0 and a_rise never asserts. Then btn_a high 4+ cycles -> a=1 with one pulse.
- Reset mid-count: btn_a high, rst pulsed 1 cycle on the 4th edge -> a=0 and counter cleared. a rises 6 edges after rst deasserts, not earlier.
- Simultaneous channels: btn_a and btn_b rise on the same cycle -> a and b rise on the same edge, a_rise and b_rise both pulse once. Downstream OR of a,b follows truth table 00->0, 01->1, 10->1, 11->1.
- Boundary STABLE_CYCLES=1: a 1-cycle btn_a high pulse -> a goes high 2 edges after sample for 1 cycle with a_rise=1. Confirms minimum latency and no counter overflow.
